// File: rtl/packet_router_rx_pkg.sv
// Shared types and constants for the packet router receive path.
package pkt_pkg;

  localparam int PKT_W    = 13;
  localparam int ENTRY_W  = 11;
  localparam int NUM_DEST = 4;
  localparam logic [1:0] PKT_TYPE_RSVD = 2'b11;

  // Link word as it arrives from the generator.
  typedef struct packed {
    logic       eop;
    logic [7:0] payload;
    logic [1:0] pkt_type;
    logic [1:0] dest_addr;
  } pkt_t;

  // What a destination FIFO stores: the packet minus its routing field.
  typedef struct packed {
    logic       eop;
    logic [7:0] payload;
    logic [1:0] pkt_type;
  } fifo_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } rx_state_e;

  // Strip the destination address off a packet to form a FIFO entry.
  function automatic fifo_entry_t to_entry(input pkt_t p);
    fifo_entry_t e;
    e.eop      = p.eop;
    e.payload  = p.payload;
    e.pkt_type = p.pkt_type;
    return e;
  endfunction

endpackage

// File: rtl/packet_router_rx_fifo.sv
// Small synchronous FIFO with a combinational head view.
// Push is ignored when full and pop is ignored when empty, so callers may
// drive them without pre-gating. The head reads as zero while empty.
module pkt_sync_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_do_pop && !w_do_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/packet_router_rx.sv
// Receive side of the packet link: accepts one packet per handshake, drops
// reserved-type packets, and steers the rest into per-destination FIFOs.
//
// Handshakes: a word moves on a posedge where valid & ready are both high.
// Upstream in_ready depends only on the FSM state register; each output
// port i presents its FIFO head on out_data while out_valid[i] is high and
// pops it on an edge where out_ready[i] is also high.
module packet_router_rx
  import pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [PKT_W-1:0]            in_packet,
  output logic [NUM_DEST-1:0]         out_valid,
  input  logic [NUM_DEST-1:0]         out_ready,
  output logic [NUM_DEST*ENTRY_W-1:0] out_data,
  output logic [CNT_W-1:0]            drop_count,
  output logic [NUM_DEST*CNT_W-1:0]   acc_count,
  output rx_state_e                   dbg_state
);

  rx_state_e          r_state;
  rx_state_e          w_next_state;
  pkt_t               r_hold;
  logic [CNT_W-1:0]   r_drop_cnt;
  logic [CNT_W-1:0]   r_acc_cnt [NUM_DEST];

  logic               w_accept;
  logic               w_drop;
  logic [NUM_DEST-1:0] w_push;
  logic [NUM_DEST-1:0] w_full;
  logic [NUM_DEST-1:0] w_empty;
  logic [ENTRY_W-1:0]  w_head [NUM_DEST];
  fifo_entry_t         w_entry;

  assign in_ready  = (r_state == IDLE);
  assign w_accept  = in_valid & in_ready;
  assign w_entry   = to_entry(r_hold);
  assign dbg_state = r_state;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Next state and per-destination push/drop decisions from the held packet.
  // Fullness is the FIFO's start-of-cycle view, so a same-cycle pop on a full
  // FIFO does not admit the push; the retry lands on the following edge.
  always_comb begin
    w_next_state = r_state;
    w_drop       = 1'b0;
    w_push       = '0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = HOLD;
      end
      HOLD: begin
        if (r_hold.pkt_type == PKT_TYPE_RSVD) begin
          w_drop       = 1'b1;
          w_next_state = IDLE;
        end else if (!w_full[r_hold.dest_addr]) begin
          w_push[r_hold.dest_addr] = 1'b1;
          w_next_state             = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Hold register captures the packet on an accepted handshake.
  always_ff @(posedge clk) begin
    if (reset)         r_hold <= '0;
    else if (w_accept) r_hold <= pkt_t'(in_packet);
  end

  // Drop counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + 1'b1;
    end
  end

  assign drop_count = r_drop_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEST; gi++) begin : g_dest
      pkt_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
      ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push[gi]),
        .i_pop   (out_ready[gi]),
        .i_din   (w_entry),
        .o_full  (w_full[gi]),
        .o_empty (w_empty[gi]),
        .o_head  (w_head[gi])
      );

      // Per-port accept counter, saturating at all-ones.
      always_ff @(posedge clk) begin
        if (reset) begin
          r_acc_cnt[gi] <= '0;
        end else if (w_push[gi] && (r_acc_cnt[gi] != '1)) begin
          r_acc_cnt[gi] <= r_acc_cnt[gi] + 1'b1;
        end
      end

      assign out_valid[gi]                   = ~w_empty[gi];
      assign out_data[ENTRY_W*gi +: ENTRY_W] = w_head[gi];
      assign acc_count[CNT_W*gi +: CNT_W]    = r_acc_cnt[gi];
    end
  endgenerate

endmodule
